aes_inv_round: RTL and testbench

- One AES decryption round (FIPS-197 inverse cipher order): InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless this is the last round.
- Iterative and area-lean. A single inverse S-box is time-shared over 16 byte-cycles. A single column-wide InvMixColumns unit is time-shared over 4 column-cycles.
- Sits on the decrypt path, opposite the forward SubBytes/ShiftRows/MixColumns round datapath, with a valid/ready handshake on each side.

---
 rtl/aes_inv_round.sv | 152 +++++++++++++++
 tb/tb_aes_inv_round.sv | 134 +++++++++++++
 2 files changed

// File: rtl/aes_inv_round.sv
// One AES inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// optional InvMixColumns. Uses one inverse S-box over 16 cycles and one column mixer over 4 cycles.
module aes_inv_round (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [31:0]  data_out1,
  output logic [31:0]  data_out2,
  output logic [31:0]  data_out3,
  output logic [31:0]  data_out4,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: sum of a, 2a, 4a, 8a selected by m's bits.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [0:15][7:0] in_q, key_q, buf_q;
  logic             last_q, in_ready_q, out_valid_q, busy_q;

  logic [1:0]      row_d, col_d, src_col_d;
  logic [3:0]      src_d;
  logic [7:0]      sub_byte_d;
  logic [0:3][7:0] col_in_d, col_out_d;

  always_comb begin
    row_d      = cnt_q[1:0];
    col_d      = cnt_q[3:2];
    src_col_d  = col_d - row_d;
    src_d      = {src_col_d, row_d};
    sub_byte_d = INV_SBOX[in_q[src_d]] ^ key_q[cnt_q];
    col_in_d[0] = buf_q[{cnt_q[1:0], 2'd0}];
    col_in_d[1] = buf_q[{cnt_q[1:0], 2'd1}];
    col_in_d[2] = buf_q[{cnt_q[1:0], 2'd2}];
    col_in_d[3] = buf_q[{cnt_q[1:0], 2'd3}];
    col_out_d[0] = gmul(col_in_d[0], 4'he) ^ gmul(col_in_d[1], 4'hb) ^ gmul(col_in_d[2], 4'hd) ^ gmul(col_in_d[3], 4'h9);
    col_out_d[1] = gmul(col_in_d[0], 4'h9) ^ gmul(col_in_d[1], 4'he) ^ gmul(col_in_d[2], 4'hb) ^ gmul(col_in_d[3], 4'hd);
    col_out_d[2] = gmul(col_in_d[0], 4'hd) ^ gmul(col_in_d[1], 4'h9) ^ gmul(col_in_d[2], 4'he) ^ gmul(col_in_d[3], 4'hb);
    col_out_d[3] = gmul(col_in_d[0], 4'hb) ^ gmul(col_in_d[1], 4'hd) ^ gmul(col_in_d[2], 4'h9) ^ gmul(col_in_d[3], 4'he);
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; data_out is held unchanged while out_valid is high and out_ready low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      in_q        <= '0;
      key_q       <= '0;
      buf_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          in_q       <= data_in;
          key_q      <= round_key;
          last_q     <= last;
          buf_q      <= '0;
          cnt_q      <= 4'd0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= SUB;
        end
        SUB: begin
          buf_q[cnt_q] <= sub_byte_d;
          cnt_q        <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_q <= 4'd0;
            if (last_q) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= MIX;
            end
          end
        end
        MIX: begin
          buf_q[{cnt_q[1:0], 2'd0}] <= col_out_d[0];
          buf_q[{cnt_q[1:0], 2'd1}] <= col_out_d[1];
          buf_q[{cnt_q[1:0], 2'd2}] <= col_out_d[2];
          buf_q[{cnt_q[1:0], 2'd3}] <= col_out_d[3];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            cnt_q       <= 4'd0;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = buf_q;
  assign data_out1 = data_out[127:96];
  assign data_out2 = data_out[95:64];
  assign data_out3 = data_out[63:32];
  assign data_out4 = data_out[31:0];

endmodule

// File: tb/tb_aes_inv_round.sv
// Directed bench for aes_inv_round: reset state, latency, known-answer
// vectors, InvShiftRows ordering, backpressure and mid-operation reset.
module tb_aes_inv_round;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] round_key;
  logic         last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [31:0]  data_out1, data_out2, data_out3, data_out4;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_inv_round dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .round_key (round_key),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .data_out4 (data_out4),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, scramble inputs afterwards, measure latency,
  // check result, optionally hold out_ready low for hold cycles.
  task automatic run(input string tag, input logic [127:0] din, input logic [127:0] key,
                     input logic lst, input logic [127:0] exp, input int lat, input int hold);
    int n;
    out_ready = (hold == 0);
    data_in   = din;
    round_key = key;
    last      = lst;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    data_in   = ~din;
    round_key = {$urandom, $urandom, $urandom, $urandom};
    last      = ~lst;
    chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
    chk({tag, "_in_ready_low"}, {127'd0, in_ready}, 128'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_data"}, data_out, exp);
    chk({tag, "_cols"}, {data_out1, data_out2, data_out3, data_out4}, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, {data_out, out_valid, in_ready}, {exp, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_handoff"}, {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    round_key = '0;
    last      = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ctrl", {125'd0, in_ready, out_valid, busy}, {125'd0, 3'b100});
      chk("idle_data", data_out, 128'd0);
    end

    run("zero_last", {16{8'h63}}, 128'd0, 1'b1, 128'd0, 16, 0);
    run("uniform_mix", {16{8'h00}}, 128'd0, 1'b0, {16{8'h52}}, 20, 0);
    run("key_xor", {16{8'h63}}, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
        128'h000102030405060708090a0b0c0d0e0f, 16, 0);
    run("mix_col0", {16{8'h63}}, {32'h8e4da1bc, 96'd0}, 1'b0, {32'hdb135345, 96'd0}, 20, 0);
    run("inv_shift", 128'h000102030405060708090a0b0c0d0e0f, 128'd0, 1'b1,
        128'h52f3a338_3009d79e_bf366afb_8140a5d5, 16, 0);
    run("backpressure", {16{8'h63}}, {32'h8e4da1bc, 96'd0}, 1'b0, {32'hdb135345, 96'd0}, 20, 50);

    // Reset while the S-box pass is at byte 7
    data_in   = 128'h000102030405060708090a0b0c0d0e0f;
    round_key = '0;
    last      = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_ctrl", {125'd0, in_ready, out_valid, busy}, {125'd0, 3'b100});
    chk("midreset_data", data_out, 128'd0);
    run("after_reset", {16{8'h63}}, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
        128'h000102030405060708090a0b0c0d0e0f, 16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
